uart_resp_framer: RTL and testbench

- Host-bound response path of the UART link; the counterpart to the RX-to-CSR command path.
- Accepts one response request at a time. Serializes it into a framed byte packet: CSR read-back, systolic result dump, or status/NACK.
- Drives the uart_tx byte interface through a valid/ready handshake.
- Sits between csr / systolic_array outputs and uart_tx inside accel_top.

---
 rtl/uart_resp_framer.sv | 166 ++++++++++++++++
 tb/tb_uart_resp_framer.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_resp_framer.sv
// uart_resp_framer: serializes CSR read-back, result-dump and status responses into
// SOF/TYPE/LEN/PAYLOAD byte frames for uart_tx. Define UART_RESP_CRC8_EN to append a CRC-8 byte.
module uart_resp_framer #(
    parameter int N_ROWS = 2,
    parameter int N_COLS = 2,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [1:0]                       req_type,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [7:0]                       status_code,
    input  logic [N_ROWS*N_COLS*ACC_W-1:0]   c_out_flat,
    output logic                             csr_ren,
    output logic [ADDR_W-1:0]                csr_addr,
    input  logic [31:0]                      csr_rdata,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             busy,
    output logic                             pkt_done
);
    localparam int FLAT_W   = N_ROWS * N_COLS * ACC_W;
    localparam int DUMP_LEN = FLAT_W / 8;

`ifdef UART_RESP_CRC8_EN
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_TYPE, S_LEN, S_PAYLOAD, S_CRC} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_TYPE, S_LEN, S_PAYLOAD} state_t;
`endif

    state_t              state;
    logic [1:0]          type_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          status_q;
    logic [FLAT_W-1:0]   shadow;
    logic [31:0]         rdata_q;
    logic                rd_pending;
    logic [7:0]          idx;

    logic [7:0]          frame_len;
    logic [7:0]          next_idx;
    logic [1:0]          rd_bsel;
    logic [7:0]          next_byte;
    logic                payload_end;
    logic                last_byte;

    assign req_ready = (state == S_IDLE) && !rst;

`ifdef UART_RESP_CRC8_EN
    logic [7:0] crc;
    logic [7:0] crc_next;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int unsigned i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign crc_next  = crc8_step(crc, tx_data);
    assign last_byte = (state == S_CRC);
`else
    assign last_byte = payload_end;
`endif

    // next_idx is the payload index loaded on the current handshake (0 when leaving LEN)
    always_comb begin
        case (type_q)
            2'd0:    frame_len = 8'd5;
            2'd1:    frame_len = 8'(DUMP_LEN);
            default: frame_len = 8'd1;
        endcase
        next_idx    = (state == S_PAYLOAD) ? idx + 8'd1 : 8'd0;
        rd_bsel     = next_idx[1:0] - 2'd1;
        payload_end = (state == S_PAYLOAD) && (idx == frame_len - 8'd1);
        case (type_q)
            2'd0:    next_byte = (next_idx == 8'd0) ? 8'(addr_q) : 8'(rdata_q >> {rd_bsel, 3'b000});
            2'd1:    next_byte = 8'(shadow >> {next_idx, 3'b000});
            2'd2:    next_byte = status_q;
            default: next_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            csr_ren    <= 1'b0;
            csr_addr   <= '0;
            busy       <= 1'b0;
            pkt_done   <= 1'b0;
            rd_pending <= 1'b0;
            idx        <= '0;
`ifdef UART_RESP_CRC8_EN
            crc        <= '0;
`endif
        end else begin
            pkt_done   <= 1'b0;
            csr_ren    <= 1'b0;
            rd_pending <= csr_ren;
            if (rd_pending)
                rdata_q <= csr_rdata;

            if (state == S_IDLE) begin
                if (req_valid && req_ready) begin
                    type_q   <= req_type;
                    addr_q   <= req_addr;
                    status_q <= status_code;
                    shadow   <= c_out_flat;
                    state    <= S_SOF;
                    tx_valid <= 1'b1;
                    tx_data  <= 8'hA5;
                    busy     <= 1'b1;
`ifdef UART_RESP_CRC8_EN
                    crc      <= '0;
`endif
                    if (req_type == 2'd0) begin
                        csr_ren  <= 1'b1;
                        csr_addr <= req_addr;
                    end
                end
            end else if (tx_valid && tx_ready) begin
`ifdef UART_RESP_CRC8_EN
                if (state != S_SOF)
                    crc <= crc_next;
`endif
                if (last_byte) begin
                    state    <= S_IDLE;
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                    busy     <= 1'b0;
                    pkt_done <= 1'b1;
                end
`ifdef UART_RESP_CRC8_EN
                else if (payload_end) begin
                    state   <= S_CRC;
                    tx_data <= crc_next;
                end
`endif
                else begin
                    case (state)
                        S_SOF: begin
                            tx_data <= 8'h80 | {6'b0, type_q};
                            state   <= S_TYPE;
                        end
                        S_TYPE: begin
                            tx_data <= frame_len;
                            state   <= S_LEN;
                        end
                        default: begin
                            idx     <= next_idx;
                            tx_data <= next_byte;
                            state   <= S_PAYLOAD;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_resp_framer.sv
// Self-checking bench for uart_resp_framer: randomized requests compared against a frame-level
// reference model; honours UART_RESP_CRC8_EN the same way as the design.
module tb_uart_resp_framer;
    localparam int N_ROWS   = 2;
    localparam int N_COLS   = 2;
    localparam int ACC_W    = 32;
    localparam int ADDR_W   = 8;
    localparam int NE       = N_ROWS * N_COLS;
    localparam int FLAT_W   = NE * ACC_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_type = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [7:0]        status_code = '0;
    logic [FLAT_W-1:0] c_out_flat = '0;
    logic              csr_ren;
    logic [ADDR_W-1:0] csr_addr;
    logic [31:0]       csr_rdata = '0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              busy;
    logic              pkt_done;

    uart_resp_framer #(
        .N_ROWS(N_ROWS),
        .N_COLS(N_COLS),
        .ACC_W (ACC_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .status_code(status_code),
        .c_out_flat (c_out_flat),
        .csr_ren    (csr_ren),
        .csr_addr   (csr_addr),
        .csr_rdata  (csr_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .pkt_done   (pkt_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // Observed traffic, sampled mid-cycle
    byte unsigned rx_q[$];
    int           hs_cyc[$];
    int           done_cnt = 0;
    int           done_cyc = -1;
    int           acc_cnt  = 0;
    int           acc_cyc  = -1;
    logic         done_busy;
    logic         done_rdy;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                hs_cyc.push_back(cyc);
            end
            if (req_valid && req_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (pkt_done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
                done_rdy  = req_ready;
            end
        end
    end

    // CSR responder: real data only in the cycle after the strobe, noise otherwise
    int                csr_pulses = 0;
    logic [ADDR_W-1:0] csr_addr_seen = '0;
    logic [31:0]       csr_value = '0;
    logic              ren_now;
    always begin
        @(negedge clk);
        ren_now = csr_ren;
        if (csr_ren) begin
            csr_pulses++;
            csr_addr_seen = csr_addr;
        end
        @(posedge clk);
        #1;
        csr_rdata = ren_now ? csr_value : $urandom;
    end

    int rdy_mode = 0;
    always begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1)
            tx_ready = 1'($urandom_range(0, 1));
    end

    // Reference model: frame bytes derived directly from the frame format rules
    byte unsigned exp_q[$];

    function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int k = 0; k < 8; k++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic model_frame(input logic [1:0] t, input logic [7:0] a, input logic [7:0] st,
                               input logic [FLAT_W-1:0] flat, input logic [31:0] rdv);
        byte unsigned p[$];
        byte unsigned f[$];
        case (t)
            2'd0: begin
                p.push_back(a);
                for (int i = 0; i < 4; i++) p.push_back(8'(rdv >> (8 * i)));
            end
            2'd1: begin
                for (int e = 0; e < NE; e++)
                    for (int b = 0; b < ACC_W / 8; b++)
                        p.push_back(8'(flat >> (e * ACC_W + 8 * b)));
            end
            2'd2: p.push_back(st);
            default: p.push_back(8'hFF);
        endcase
        f.push_back(8'hA5);
        f.push_back(8'(8'h80 + {6'b0, t}));
        f.push_back(8'(p.size()));
        foreach (p[i]) f.push_back(p[i]);
`ifdef UART_RESP_CRC8_EN
        begin
            logic [7:0] c;
            c = 8'h00;
            for (int i = 1; i < f.size(); i++) c = crc8(c, f[i]);
            f.push_back(c);
        end
`endif
        foreach (f[i]) exp_q.push_back(f[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rx_q.delete();
        hs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic send_req(input logic [1:0] t, input logic [7:0] a, input logic [7:0] st,
                            input logic [FLAT_W-1:0] flat, output bit ok);
        int n0;
        n0 = acc_cnt;
        req_valid = 1'b1;
        req_type = t;
        req_addr = a;
        status_code = st;
        c_out_flat = flat;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            ok = (acc_cnt != n0);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            ok = (done_cnt >= target);
        end
    endtask

    function automatic logic [FLAT_W-1:0] rand_flat();
        logic [FLAT_W-1:0] v;
        for (int i = 0; i < FLAT_W / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        total++; if (csr_ren !== 1'b0) begin bad++; $display("FAIL reset_csr_ren: got %b expected 0", csr_ren); end
        total++; if (csr_addr !== '0) begin bad++; $display("FAIL reset_csr_addr: got %h expected 00", csr_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL reset_pkt_done: got %b expected 0", pkt_done); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready: got %b expected 1", req_ready); end
        tick();
    endtask

    task automatic test_status();
        bit ok;
        int n;
        clear_q();
        tx_ready = 1'b1;
        n = done_cnt;
        send_req(2'd2, 8'h00, 8'h3C, '0, ok);
        model_frame(2'd2, 8'h00, 8'h3C, '0, 32'h0);
        total++; if (!ok) begin bad++; $display("FAIL status_accept: got timeout expected accept"); end
        wait_done(n + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL status_done: got timeout expected pkt_done"); end
        repeat (3) tick();
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL status_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL status_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        total++; if (done_cnt !== n + 1) begin bad++; $display("FAIL status_done_count: got %0d expected %0d", done_cnt - n, 1); end
        total++; if (done_busy !== 1'b0 || done_rdy !== 1'b1) begin bad++; $display("FAIL status_done_idle: got busy=%b ready=%b expected busy=0 ready=1", done_busy, done_rdy); end
        if (hs_cyc.size() > 0) begin
            total++; if (hs_cyc[0] !== acc_cyc + 1) begin bad++; $display("FAIL status_first_byte_cycle: got %0d expected %0d", hs_cyc[0], acc_cyc + 1); end
            total++; if (hs_cyc[hs_cyc.size()-1] - hs_cyc[0] !== hs_cyc.size() - 1) begin bad++; $display("FAIL status_zero_bubble: got span %0d expected %0d", hs_cyc[hs_cyc.size()-1] - hs_cyc[0], hs_cyc.size() - 1); end
            total++; if (done_cyc !== hs_cyc[hs_cyc.size()-1] + 1) begin bad++; $display("FAIL status_done_cycle: got %0d expected %0d", done_cyc, hs_cyc[hs_cyc.size()-1] + 1); end
        end
    endtask

    task automatic test_csr();
        bit ok;
        int n;
        int p0;
        logic [7:0] a;
        for (int r = 0; r < 4; r++) begin
            clear_q();
            if (r == 0) begin
                a = 8'h10;
                csr_value = 32'hDEADBEEF;
                rdy_mode = 0;
                tx_ready = 1'b1;
            end else begin
                a = 8'($urandom);
                csr_value = $urandom;
                rdy_mode = 1;
            end
            n = done_cnt;
            p0 = csr_pulses;
            send_req(2'd0, a, 8'($urandom), rand_flat(), ok);
            model_frame(2'd0, a, 8'h00, '0, csr_value);
            wait_done(n + 1, ok);
            total++; if (!ok) begin bad++; $display("FAIL csr%0d_done: got timeout expected pkt_done", r); end
            total++; if (csr_pulses - p0 !== 1) begin bad++; $display("FAIL csr%0d_strobes: got %0d expected 1", r, csr_pulses - p0); end
            total++; if (csr_addr_seen !== a) begin bad++; $display("FAIL csr%0d_addr: got %h expected %h", r, csr_addr_seen, a); end
            total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL csr%0d_len: got %0d expected %0d", r, rx_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL csr%0d_byte%0d: got %h expected %h", r, i, rx_q[i], exp_q[i]); end
            end
        end
        rdy_mode = 0;
        tx_ready = 1'b1;
        tick();
    endtask

    task automatic test_dump();
        bit ok;
        int n;
        logic [FLAT_W-1:0] flat;
        for (int r = 0; r < 4; r++) begin
            clear_q();
            if (r == 0) begin
                flat = {32'h80000000, 32'hFFFFFFFF, 32'h00000102, 32'h00000001};
                rdy_mode = 0;
                tx_ready = 1'b1;
            end else begin
                flat = rand_flat();
                rdy_mode = 1;
            end
            n = done_cnt;
            send_req(2'd1, 8'($urandom), 8'($urandom), flat, ok);
            c_out_flat = '0;
            model_frame(2'd1, 8'h00, 8'h00, flat, 32'h0);
            wait_done(n + 1, ok);
            total++; if (!ok) begin bad++; $display("FAIL dump%0d_done: got timeout expected pkt_done", r); end
            total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL dump%0d_len: got %0d expected %0d", r, rx_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL dump%0d_byte%0d: got %h expected %h", r, i, rx_q[i], exp_q[i]); end
            end
        end
        rdy_mode = 0;
        tx_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit prev_stall;
        int n;
        logic [7:0] prev_data;
        logic [FLAT_W-1:0] flat;
        clear_q();
        rdy_mode = 2;
        tx_ready = 1'b1;
        flat = rand_flat();
        n = done_cnt;
        send_req(2'd1, 8'h00, 8'h00, flat, ok);
        model_frame(2'd1, 8'h00, 8'h00, flat, 32'h0);
        for (int i = 0; i < 50 && rx_q.size() < 5; i++) tick();
        tx_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            total++; if (tx_valid !== 1'b1 || tx_data !== exp_q[5]) begin bad++; $display("FAIL stall%0d_hold: got valid=%b data=%h expected valid=1 data=%h", s, tx_valid, tx_data, exp_q[5]); end
            tick();
        end
        total++; if (rx_q.size() !== 5) begin bad++; $display("FAIL stall_no_transfer: got %0d bytes expected 5", rx_q.size()); end
        prev_stall = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 1000 && done_cnt == n; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                total++; if (tx_valid !== 1'b1 || tx_data !== prev_data) begin bad++; $display("FAIL toggle_hold: got valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, prev_data); end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
            tick();
        end
        tx_ready = 1'b1;
        rdy_mode = 0;
        total++; if (done_cnt !== n + 1) begin bad++; $display("FAIL bp_done: got %0d frames expected 1", done_cnt - n); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        int a0;
        logic [7:0] st;
        clear_q();
        tx_ready = 1'b1;
        st = 8'($urandom);
        n = done_cnt;
        a0 = acc_cnt;
        req_valid = 1'b1;
        req_type = 2'd2;
        status_code = st;
        for (int i = 0; i < 50 && acc_cnt == a0; i++) tick();
        req_type = 2'd3;
        for (int i = 0; i < 50 && acc_cnt == a0 + 1; i++) tick();
        req_valid = 1'b0;
        total++; if (acc_cnt !== a0 + 2) begin bad++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt - a0); end
        total++; if (acc_cyc !== done_cyc || done_cnt !== n + 1) begin bad++; $display("FAIL b2b_accept_cycle: got %0d expected %0d", acc_cyc, done_cyc); end
        model_frame(2'd2, 8'h00, st, '0, 32'h0);
        model_frame(2'd3, 8'h00, 8'h00, '0, 32'h0);
        wait_done(n + 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_done: got timeout expected 2 frames"); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        int sz;
        clear_q();
        tx_ready = 1'b1;
        n = done_cnt;
        send_req(2'd1, 8'h00, 8'h00, rand_flat(), ok);
        for (int i = 0; i < 50 && rx_q.size() < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || pkt_done !== 1'b0) begin bad++; $display("FAIL rstmid_outputs: got valid=%b busy=%b done=%b expected 0 0 0", tx_valid, busy, pkt_done); end
        sz = rx_q.size();
        repeat (6) tick();
        total++; if (rx_q.size() !== sz || done_cnt !== n) begin bad++; $display("FAIL rstmid_abandon: got bytes=%0d frames=%0d expected bytes=%0d frames=%0d", rx_q.size(), done_cnt - n, sz, 0); end
        clear_q();
        send_req(2'd2, 8'h00, 8'h5A, '0, ok);
        model_frame(2'd2, 8'h00, 8'h5A, '0, 32'h0);
        wait_done(n + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_fresh_done: got timeout expected pkt_done"); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL rstmid_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_random();
        bit ok;
        int n;
        logic [1:0] t;
        logic [7:0] a;
        logic [7:0] st;
        logic [FLAT_W-1:0] flat;
        rdy_mode = 1;
        for (int r = 0; r < 10; r++) begin
            clear_q();
            t = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            st = 8'($urandom);
            flat = rand_flat();
            csr_value = $urandom;
            n = done_cnt;
            send_req(t, a, st, flat, ok);
            c_out_flat = rand_flat();
            model_frame(t, a, st, flat, csr_value);
            wait_done(n + 1, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand%0d_done: got timeout expected pkt_done", r); end
            total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand%0d_len: got %0d expected %0d", r, rx_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d: got %h expected %h", r, i, rx_q[i], exp_q[i]); end
            end
        end
        rdy_mode = 0;
        tx_ready = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_status();
        test_csr();
        test_dump();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
